// File: rtl/fetch_sequencer_if.sv
// Fetch-path handshake bundle between the fetch sequencer, instruction memory
// and the execute stage. The sequencer side is the master modport.
interface fetch_sequencer_if #(
    parameter int unsigned ADDR_SIZE = 16
) ();

    // Instruction-memory read channel
    logic                 mem_req;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic                 mem_ready;

    // Instruction-register capture strobe towards fetch_instruction
    logic                 fetch_enable;

    // Execute-stage handshake and branch redirect
    logic                 exec_start;
    logic                 exec_done;
    logic                 branch_taken;
    logic [ADDR_SIZE-1:0] branch_target;

    modport master (
        output mem_req,
        output mem_addr,
        output fetch_enable,
        output exec_start,
        input  mem_ready,
        input  exec_done,
        input  branch_taken,
        input  branch_target
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        input  fetch_enable,
        input  exec_start,
        output mem_ready,
        output exec_done,
        output branch_taken,
        output branch_target
    );

endinterface

// File: rtl/fetch_sequencer.sv
// Control FSM for the instruction fetch path: sequences the PC, issues
// instruction-memory reads, strobes the instruction register, hands off to
// execute, bounds memory wait states and counts retired instructions.
module fetch_sequencer #(
    parameter int unsigned          WORD_SIZE    = 16,
    parameter int unsigned          ADDR_SIZE    = 16,
    parameter logic [ADDR_SIZE-1:0] RESET_PC     = '0,
    parameter int unsigned          WAIT_TIMEOUT = 15
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 halt,
    fetch_sequencer_if.master    bus,
    output logic [ADDR_SIZE-1:0] pc,
    output logic [15:0]          retired,
    output logic                 busy,
    output logic                 fault,
    output logic [2:0]           state
);

    localparam int unsigned RETIRED_W = 16;
    localparam int unsigned WAIT_W    = 8;
    // Last wait-counter value tolerated before the fetch is declared dead
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    state_t                 state_q;
    state_t                 state_d;

    logic [ADDR_SIZE-1:0]   pc_q;
    logic [RETIRED_W-1:0]   retired_q;
    logic [WAIT_W-1:0]      wait_q;
    logic                   halt_pending_q;

    // Registered Moore strobes, loaded from the next-state decode
    logic                   mem_req_q;
    logic                   exec_start_q;
    logic                   busy_q;
    logic                   fault_q;

    logic                   mem_req_d;
    logic                   exec_start_d;
    logic                   busy_d;
    logic                   fault_d;

    // Combinational qualifiers
    logic                   fetch_enable_c;
    logic                   retire_c;
    logic                   wait_inc_c;

    // State register and registered Moore outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            mem_req_q    <= 1'b0;
            exec_start_q <= 1'b0;
            busy_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            exec_start_q <= exec_start_d;
            busy_q       <= busy_d;
            fault_q      <= fault_d;
        end
    end

    // Next-state decode; a halt request only takes effect at the retire point
    always_comb begin
        state_d    = state_q;
        retire_c   = 1'b0;
        wait_inc_c = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // Data arriving on the timeout cycle still wins over the fault
                if (bus.mem_ready) begin
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    wait_inc_c = 1'b1;
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (bus.exec_done) begin
                    retire_c = 1'b1;
                    state_d  = (halt_pending_q || halt) ? S_IDLE : S_FETCH;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode: Moore strobes for the coming state, Mealy capture strobe
    always_comb begin
        mem_req_d      = 1'b0;
        exec_start_d   = 1'b0;
        busy_d         = 1'b0;
        fault_d        = 1'b0;
        fetch_enable_c = 1'b0;
        unique case (state_d)
            S_FETCH: begin
                mem_req_d = 1'b1;
                busy_d    = 1'b1;
            end
            S_DECODE: begin
                exec_start_d = 1'b1;
                busy_d       = 1'b1;
            end
            S_EXEC: begin
                busy_d = 1'b1;
            end
            S_FAULT: begin
                fault_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
        // Capture on the same edge that memory presents the word
        fetch_enable_c = mem_req_q & bus.mem_ready;
    end

    // PC, retire counter, wait counter and pending-halt bookkeeping
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q           <= RESET_PC;
            retired_q      <= '0;
            wait_q         <= '0;
            halt_pending_q <= 1'b0;
        end else begin
            if (retire_c) begin
                pc_q      <= bus.branch_taken ? bus.branch_target
                                              : pc_q + ADDR_SIZE'(1);
                retired_q <= retired_q + RETIRED_W'(1);
            end

            // Counter only runs while a fetch stalls, so every FETCH entry starts at 0
            if (wait_inc_c) begin
                wait_q <= wait_q + WAIT_W'(1);
            end else begin
                wait_q <= '0;
            end

            if (state_d == S_IDLE) begin
                halt_pending_q <= 1'b0;
            end else if (halt && busy_q) begin
                halt_pending_q <= 1'b1;
            end
        end
    end

    // Invariants on the strobes and parameter range
    always_ff @(posedge clock) begin
        if (reset_n) begin
            assert (WAIT_TIMEOUT >= 1 && WAIT_TIMEOUT <= 255 && WORD_SIZE > 0)
                else $error("fetch_sequencer: parameter out of range");
            assert (!fetch_enable_c || state_q == S_FETCH)
                else $error("fetch_sequencer: capture strobe outside FETCH");
            assert (mem_req_q == (state_q == S_FETCH))
                else $error("fetch_sequencer: mem_req out of step with state");
            assert (exec_start_q == (state_q == S_DECODE))
                else $error("fetch_sequencer: exec_start out of step with state");
            assert (fault_q == (state_q == S_FAULT))
                else $error("fetch_sequencer: fault out of step with state");
        end
    end

    assign bus.mem_req      = mem_req_q;
    assign bus.mem_addr     = pc_q;
    assign bus.fetch_enable = fetch_enable_c;
    assign bus.exec_start   = exec_start_q;

    assign pc      = pc_q;
    assign retired = retired_q;
    assign busy    = busy_q;
    assign fault   = fault_q;
    assign state   = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: reset, basic 3-cycle sequencing, wait
// states, branch/wrap, halt, timeout boundary and asynchronous reset mid-fetch.
module tb_fetch_sequencer;

    localparam int unsigned ADDR_SIZE = 16;

    logic                 clock = 1'b0;
    logic                 reset_n;
    logic                 start;
    logic                 halt;
    logic [ADDR_SIZE-1:0] pc;
    logic [15:0]          retired;
    logic                 busy;
    logic                 fault;
    logic [2:0]           state;

    logic [15:0]          mem_data;
    logic [15:0]          ir = '0;

    int unsigned          n_checks = 0;
    int unsigned          n_fail   = 0;

    fetch_sequencer_if #(.ADDR_SIZE(ADDR_SIZE)) bus ();

    fetch_sequencer #(
        .WORD_SIZE    (16),
        .ADDR_SIZE    (ADDR_SIZE),
        .RESET_PC     (16'h0000),
        .WAIT_TIMEOUT (15)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .halt    (halt),
        .bus     (bus),
        .pc      (pc),
        .retired (retired),
        .busy    (busy),
        .fault   (fault),
        .state   (state)
    );

    always #5 clock = ~clock;

    // Stand-in for the instruction register inside fetch_instruction
    always @(posedge clock) begin
        if (bus.fetch_enable) ir <= mem_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_quiet(input string tag);
        check({tag, "_state"},  32'(state),            32'd0);
        check({tag, "_pc"},     32'(pc),               32'h0000);
        check({tag, "_ret"},    32'(retired),          32'd0);
        check({tag, "_req"},    32'(bus.mem_req),      32'd0);
        check({tag, "_addr"},   32'(bus.mem_addr),     32'h0000);
        check({tag, "_fe"},     32'(bus.fetch_enable), 32'd0);
        check({tag, "_es"},     32'(bus.exec_start),   32'd0);
        check({tag, "_busy"},   32'(busy),             32'd0);
        check({tag, "_fault"},  32'(fault),            32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n           = 1'b0;
        start             = 1'b0;
        halt              = 1'b0;
        bus.mem_ready     = 1'b0;
        bus.exec_done     = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;
        mem_data          = 16'h0000;

        // Reset state
        #12;
        check_all_quiet("reset");
        @(negedge clock);
        reset_n = 1'b1;

        // Basic sequence: start sampled after cycle 0, three instructions, halt in 3rd DECODE
        @(negedge clock);
        start         = 1'b1;
        bus.mem_ready = 1'b1;
        bus.exec_done = 1'b1;
        mem_data      = 16'h1111;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clock);
            start = 1'b0;
            halt  = (c == 8);
            #1;
            check("basic_fe", 32'(bus.fetch_enable), 32'(c % 3 == 1));
            check("basic_es", 32'(bus.exec_start),   32'(c % 3 == 2));
            if (c % 3 == 1) check("basic_addr", 32'(bus.mem_addr), 32'((c - 1) / 3));
        end
        @(negedge clock);
        halt = 1'b0;
        #1;
        check("basic_state", 32'(state),   32'd0);
        check("basic_busy",  32'(busy),    32'd0);
        check("basic_ret",   32'(retired), 32'd3);
        check("basic_pc",    32'(pc),      32'h0003);

        // Wait states: four stalled FETCH cycles, data 0xABCD on the fifth
        start         = 1'b1;
        bus.mem_ready = 1'b0;
        bus.exec_done = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            start         = 1'b0;
            bus.mem_ready = (c == 5);
            mem_data      = (c == 5) ? 16'hABCD : 16'h5555;
            #1;
            check("wait_state", 32'(state),            32'd1);
            check("wait_fe",    32'(bus.fetch_enable), 32'(c == 5));
            check("wait_addr",  32'(bus.mem_addr),     32'h0003);
        end
        @(negedge clock);
        bus.mem_ready = 1'b0;
        #1;
        check("wait_ir",    32'(ir),             32'hABCD);
        check("wait_es",    32'(bus.exec_start), 32'd1);
        check("wait_fault", 32'(fault),          32'd0);

        // Branch to 0xFFFF; memory ready during EXEC must not strobe capture
        @(negedge clock);
        bus.mem_ready     = 1'b1;
        bus.exec_done     = 1'b1;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 16'hFFFF;
        #1;
        check("br_exec_state", 32'(state),            32'd3);
        check("br_exec_req",   32'(bus.mem_req),      32'd0);
        check("br_exec_fe",    32'(bus.fetch_enable), 32'd0);
        @(negedge clock);
        bus.branch_taken  = 1'b0;
        bus.branch_target = 16'h1234;
        bus.exec_done     = 1'b0;
        #1;
        check("br_addr", 32'(bus.mem_addr), 32'h0000FFFF);
        check("br_ret",  32'(retired),      32'd4);

        // DECODE, then branch_taken without exec_done, then plain retire -> wrap to 0
        @(negedge clock);
        bus.mem_ready = 1'b0;
        #1;
        check("wrap_es", 32'(bus.exec_start), 32'd1);
        @(negedge clock);
        bus.branch_taken  = 1'b1;
        bus.branch_target = 16'h4444;
        #1;
        check("wrap_exec1", 32'(state), 32'd3);
        @(negedge clock);
        bus.branch_taken = 1'b0;
        bus.exec_done    = 1'b1;
        #1;
        check("wrap_exec2", 32'(state), 32'd3);
        @(negedge clock);
        bus.exec_done = 1'b0;
        halt          = 1'b1;
        #1;
        check("wrap_state", 32'(state),        32'd1);
        check("wrap_addr",  32'(bus.mem_addr), 32'h0000);
        check("wrap_ret",   32'(retired),      32'd5);

        // Halt pulsed during a fetch stall: instruction still completes, then IDLE
        @(negedge clock);
        halt = 1'b0;
        #1;
        check("halt_still_fetch", 32'(state), 32'd1);
        check("halt_busy",        32'(busy),  32'd1);
        @(negedge clock);
        bus.mem_ready = 1'b1;
        #1;
        check("halt_fe", 32'(bus.fetch_enable), 32'd1);
        @(negedge clock);
        bus.mem_ready = 1'b0;
        #1;
        check("halt_es", 32'(bus.exec_start), 32'd1);
        @(negedge clock);
        bus.exec_done = 1'b1;
        @(negedge clock);
        bus.exec_done = 1'b0;
        #1;
        check("halt_state", 32'(state),   32'd0);
        check("halt_busy0", 32'(busy),    32'd0);
        check("halt_ret",   32'(retired), 32'd6);
        check("halt_pc",    32'(pc),      32'h0001);

        // Resume at PC+1 and let the fetch time out
        start = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clock);
            start = 1'b0;
            #1;
            if (k == 1) check("resume_addr", 32'(bus.mem_addr), 32'h0001);
            check("to_fetch", 32'(state), 32'd1);
        end
        @(negedge clock);
        #1;
        check("to_state", 32'(state),       32'd4);
        check("to_fault", 32'(fault),       32'd1);
        check("to_req",   32'(bus.mem_req), 32'd0);
        check("to_busy",  32'(busy),        32'd0);
        check("to_pc",    32'(pc),          32'h0001);

        // Fault is sticky while start and handshakes toggle
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            start         = (i % 2 == 0);
            bus.mem_ready = 1'b1;
            bus.exec_done = 1'b1;
            #1;
            check("sticky_state", 32'(state),            32'd4);
            check("sticky_fault", 32'(fault),            32'd1);
            check("sticky_fe",    32'(bus.fetch_enable), 32'd0);
            check("sticky_es",    32'(bus.exec_start),   32'd0);
        end
        @(negedge clock);
        start         = 1'b0;
        bus.mem_ready = 1'b0;
        bus.exec_done = 1'b0;
        reset_n       = 1'b0;
        #1;
        check_all_quiet("fault_clr");
        @(negedge clock);
        reset_n = 1'b1;

        // Data on the timeout cycle beats the fault
        @(negedge clock);
        start = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clock);
            start         = 1'b0;
            bus.mem_ready = (k == 15);
            #1;
            if (k == 15) check("edge_fe", 32'(bus.fetch_enable), 32'd1);
        end
        @(negedge clock);
        bus.mem_ready = 1'b0;
        #1;
        check("edge_state", 32'(state), 32'd2);
        check("edge_fault", 32'(fault), 32'd0);
        @(negedge clock);
        bus.exec_done = 1'b1;
        @(negedge clock);
        bus.exec_done = 1'b0;
        #1;
        check("edge_next", 32'(state),       32'd1);
        check("edge_req",  32'(bus.mem_req), 32'd1);
        check("edge_pc",   32'(pc),          32'h0001);
        check("edge_ret",  32'(retired),     32'd1);

        // Asynchronous reset in the middle of a stalled fetch, no clock edge
        #2;
        reset_n = 1'b0;
        #1;
        check_all_quiet("rst_mid");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Control FSM for the 16-bit binary core's instruction fetch path. It sequences the program counter, issues instruction-memory read requests, and drives `fetch_enable` into `fetch_instruction` so the instruction register captures exactly one word per instruction. It then hands off to the execute stage and advances the PC (sequential or branch). It also bounds memory wait states and counts retired instructions.

## Interface
- `WORD_SIZE`, 16, datapath/instruction width.
- `ADDR_SIZE`, 16, program-counter and memory-address width.
- `RESET_PC`, 0, PC value loaded on reset.
- `WAIT_TIMEOUT`, 15, maximum FETCH cycles without `mem_ready` before a fault. Legal range 1..255.

Ports:
- `clock` in 1: single clock, all state updates on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: leave IDLE and begin fetching at the current PC.
- `halt` in 1: request a stop at the next instruction boundary.
- `mem_ready` in 1: instruction memory data valid this cycle.
- `exec_done` in 1: execute stage has finished the current instruction.
- `branch_taken` in 1: qualifies `branch_target`; sampled with `exec_done`.
- `branch_target` in ADDR_SIZE: next PC when a branch is taken.
- `mem_req` out 1: instruction memory read request.
- `mem_addr` out ADDR_SIZE: read address; always equals `pc`.
- `fetch_enable` out 1: capture strobe to `fetch_instruction`.
- `exec_start` out 1: one-cycle pulse telling the execute stage the instruction register is valid.
- `pc` out ADDR_SIZE: current program counter.
- `retired` out 16: count of completed instructions.
- `busy` out 1: high in FETCH, DECODE and EXEC.
- `fault` out 1: sticky flag for a fetch timeout.
- `state` out 3: IDLE=0, FETCH=1, DECODE=2, EXEC=3, FAULT=4.

## Operation
- **Reset (asynchronous, immediate):** state=IDLE, `pc`=RESET_PC. `retired`, wait counter and `halt_pending` are cleared to 0. All 1-bit outputs are 0, including a `mem_req` that was active mid-fetch.
- **IDLE:**
  - `start`=1 → FETCH.
  - `halt` is ignored here, and `halt_pending` is held at 0.
- **FETCH:**
  - `mem_req`=1 (Moore).
  - `fetch_enable` = `mem_req` & `mem_ready` (Mealy), so the instruction register captures on the same edge that memory presents data.
  - `mem_ready`=1 → DECODE; the wait counter clears.
  - Otherwise the wait counter increments. If the counter equals WAIT_TIMEOUT-1 while `mem_ready`=0 → FAULT.
  - If `mem_ready` arrives on the timeout cycle, `mem_ready` wins.
- **DECODE:**
  - `exec_start`=1 for exactly this one cycle.
  - Always → EXEC next cycle.
- **EXEC:**
  - Waits for `exec_done`, which may already be high on the first EXEC cycle.
  - On `exec_done`:
    - `pc` ← `branch_target` if `branch_taken`, else `pc`+1, with wrap-around 0xFFFF→0x0000.
    - `retired` ← `retired`+1, wrapping.
    - Next state is IDLE if `halt_pending` is set (or `halt` is high this cycle), otherwise FETCH.
  - `branch_taken` without `exec_done` is ignored.
- **halt_pending:**
  - Set when `halt`=1 in FETCH, DECODE or EXEC.
  - Cleared on entry to IDLE.
  - The in-flight instruction always completes; a halt never aborts a fetch.
- **FAULT:**
  - Terminal state: `fault`=1 and all other strobes are 0.
  - `pc` holds the faulting address.
  - Exit only via `reset_n`.
- **Derived outputs:**
  - `fetch_enable` is never high outside FETCH.
  - `mem_req` and `fetch_enable` are never high in DECODE or EXEC.

## Timing
- `start` is sampled at edge N; FETCH occupies cycle N→N+1.
- With `mem_ready` immediate, capture happens at edge N+1. DECODE runs in cycle N+1→N+2, with `exec_start` high. EXEC starts at N+2.
- Minimum instruction period is 3 cycles (FETCH, DECODE, EXEC). Each memory wait cycle adds 1.
- The PC update and `retired` increment are visible the cycle after the `exec_done` edge. The next FETCH presents the new `mem_addr` in its first cycle.
- The wait counter restarts at 0 on every FETCH entry.
- `start` asserted while busy has no effect.

## Test plan
- **Reset mid-fetch:** assert `reset_n`=0 while in FETCH with `mem_ready` low → `mem_req`=0, `state`=0 and `pc`=RESET_PC with no clock edge; all outputs are 0.
- **Basic sequence:** `start` pulse, `mem_ready` always 1, `exec_done` on the first EXEC cycle, 3 instructions →
  - `fetch_enable` pulses on cycles 1, 4 and 7;
  - `exec_start` pulses on cycles 2, 5 and 8;
  - `mem_addr` reads 0x0000, 0x0001, 0x0002;
  - `retired`=3.
- **Wait states:** `mem_ready` low for 4 FETCH cycles, then high with data 0xABCD → `fetch_enable` is high only on the 5th FETCH cycle, the fetch stage holds 0xABCD, and `fault`=0.
- **Timeout:** `mem_ready` never asserts, WAIT_TIMEOUT=15 → `state`=4 and `fault`=1 after 15 FETCH cycles. The fault persists while `start` toggles and clears only on `reset_n`.
- **Branch and wrap:**
  - `exec_done` with `branch_taken`=1 and `branch_target`=0xFFFF → next `mem_addr`=0xFFFF.
  - The following non-branch instruction → `mem_addr`=0x0000.
- **Halt:** assert `halt` for 1 cycle during a FETCH wait state → the instruction still completes (`exec_start` seen, `retired`+1), then `state`=0 and `busy`=0. A new `start` resumes at PC+1.
